pattern_run_counter: RTL and testbench

//  Counts occurrences of a programmable PAT_W-bit pattern in a serial bit stream,
//  e.g. the LFSR MSB. Counting is done per measurement window, and max_tick closes

---
 rtl/pattern_run_counter_if.sv | 28 ++
 rtl/pattern_run_counter.sv | 104 ++++++++++
 tb/tb_pattern_run_counter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_run_counter_if.sv
// Bundle of stream, configuration and result signals for pattern_run_counter.
//   master : drives bit_valid, bit_in, max_tick, pattern, overlap_en;
//            observes count, result, result_valid, result_sat
//   slave  : the counter side (inputs/outputs reversed)
interface pattern_run_counter_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 17
);
  logic             bit_valid;
  logic             bit_in;
  logic             max_tick;
  logic [PAT_W-1:0] pattern;
  logic             overlap_en;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] result;
  logic             result_valid;
  logic             result_sat;

  modport master (
    output bit_valid, bit_in, max_tick, pattern, overlap_en,
    input  count, result, result_valid, result_sat
  );

  modport slave (
    input  bit_valid, bit_in, max_tick, pattern, overlap_en,
    output count, result, result_valid, result_sat
  );
endinterface

// File: rtl/pattern_run_counter.sv
// pattern_run_counter
//   Counts occurrences of a programmable PAT_W-bit pattern in a qualified serial
//   bit stream, per measurement window. max_tick closes a window: the window's
//   count (including a match on the closing cycle's bit) is latched into result
//   with a one-cycle result_valid pulse. Overlapping or non-overlapping matching,
//   saturating count with a sticky saturation flag.
// Ports
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : slave side of pattern_run_counter_if
//            in : bit_valid, bit_in, max_tick, pattern[PAT_W-1:0] (MSB oldest),
//                 overlap_en
//            out: count, result, result_valid, result_sat (all registered)
module pattern_run_counter #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 17
) (
  input logic                   clk,
  input logic                   reset,
  pattern_run_counter_if.slave  bus
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [PAT_W-1:0]  r_pat;
  logic              r_ovl;
  logic              r_sat;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_result;
  logic              r_result_valid;
  logic              r_result_sat;

  logic [PAT_W-1:0]  w_window;
  logic [PAT_W-1:0]  w_bit_eq;
  logic              w_match;
  logic              w_count_full;
  logic [CNT_W-1:0]  w_count_inc;
  logic              w_sat_now;

  // Candidate window: stored history plus the bit arriving this cycle.
  assign w_window = {r_hist[PAT_W-2:0], bus.bit_in};

  genvar gi;
  generate
    for (gi = 0; gi < PAT_W; gi++) begin : g_bit_cmp
      assign w_bit_eq[gi] = ~(w_window[gi] ^ r_pat[gi]);
    end
  endgenerate

  // History must hold PAT_W-1 valid bits before the incoming bit completes a match.
  assign w_match      = bus.bit_valid && (r_fill >= FILL_W'(PAT_W - 1)) && (&w_bit_eq);
  assign w_count_full = &r_count;
  assign w_count_inc  = (w_match && !w_count_full) ? r_count + 1'b1 : r_count;
  assign w_sat_now    = w_match && w_count_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist         <= '0;
      r_fill         <= '0;
      r_sat          <= 1'b0;
      r_count        <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_result_sat   <= 1'b0;
      r_pat          <= bus.pattern;
      r_ovl          <= bus.overlap_en;
    end else if (bus.max_tick) begin
      // Closing cycle: this cycle's bit still counts, then everything restarts
      // so no match can straddle two windows.
      r_result       <= w_count_inc;
      r_result_sat   <= r_sat | w_sat_now;
      r_result_valid <= 1'b1;
      r_hist         <= '0;
      r_fill         <= '0;
      r_sat          <= 1'b0;
      r_count        <= '0;
      r_pat          <= bus.pattern;
      r_ovl          <= bus.overlap_en;
    end else begin
      r_result_valid <= 1'b0;
      r_count        <= w_count_inc;
      if (w_sat_now) begin
        r_sat <= 1'b1;
      end
      if (bus.bit_valid) begin
        r_hist <= w_window;
        // Non-overlapping mode demands PAT_W fresh bits after each match.
        if (w_match && !r_ovl) begin
          r_fill <= '0;
        end else if (r_fill < FILL_W'(PAT_W)) begin
          r_fill <= r_fill + 1'b1;
        end
      end
    end
  end

  assign bus.count        = r_count;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.result_sat   = r_result_sat;

endmodule

// File: tb/tb_pattern_run_counter.sv
// Directed bench for pattern_run_counter. Two instances share the stimulus:
// dut_a (CNT_W=17) and dut_b (CNT_W=3, for saturation). A bit-queue model
// predicts counts; window results are pushed to scoreboard queues when
// max_tick is driven and popped when result_valid is seen.
module tb_pattern_run_counter;
  localparam int PAT_W = 4;
  localparam int MAX_A = (1 << 17) - 1;
  localparam int MAX_B = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pattern_run_counter_if #(.PAT_W(PAT_W), .CNT_W(17)) ia ();
  pattern_run_counter_if #(.PAT_W(PAT_W), .CNT_W(3))  ib ();

  pattern_run_counter #(.PAT_W(PAT_W), .CNT_W(17)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ia.slave)
  );

  pattern_run_counter #(.PAT_W(PAT_W), .CNT_W(3)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ib.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Model state
  bit             m_bits[$];
  int             m_cnt_a, m_cnt_b;
  bit             m_sat_a, m_sat_b;
  logic [PAT_W-1:0] m_pat;
  bit             m_ovl;
  bit             m_rv;
  int             qa_res[$], qb_res[$];
  bit             qa_sat[$], qb_sat[$];

  logic [PAT_W-1:0] drv_pat;
  logic             drv_ovl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_clear();
    m_bits.delete();
    m_cnt_a = 0;
    m_cnt_b = 0;
    m_sat_a = 0;
    m_sat_b = 0;
  endtask

  task automatic step(input logic r, input logic v, input logic b, input logic t);
    bit m;
    reset = r;
    ia.bit_valid = v;  ib.bit_valid = v;
    ia.bit_in    = b;  ib.bit_in    = b;
    ia.max_tick  = t;  ib.max_tick  = t;
    ia.pattern   = drv_pat;  ib.pattern   = drv_pat;
    ia.overlap_en = drv_ovl; ib.overlap_en = drv_ovl;
    if (r) begin
      model_clear();
      m_pat = drv_pat;
      m_ovl = drv_ovl;
      m_rv  = 0;
    end else begin
      m = 0;
      if (v) begin
        m_bits.push_back(b);
        if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
        if (m_bits.size() == PAT_W) begin
          m = 1;
          for (int k = 0; k < PAT_W; k++)
            if (m_bits[k] != m_pat[PAT_W-1-k]) m = 0;
        end
        if (m && !m_ovl) m_bits.delete();
      end
      if (m) begin
        if (m_cnt_a == MAX_A) m_sat_a = 1; else m_cnt_a++;
        if (m_cnt_b == MAX_B) m_sat_b = 1; else m_cnt_b++;
      end
      if (t) begin
        qa_res.push_back(m_cnt_a); qa_sat.push_back(m_sat_a);
        qb_res.push_back(m_cnt_b); qb_sat.push_back(m_sat_b);
        model_clear();
        m_pat = drv_pat;
        m_ovl = drv_ovl;
        m_rv  = 1;
      end else begin
        m_rv = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("count_a", ia.count, m_cnt_a);
    chk("count_b", ib.count, m_cnt_b);
    chk("result_valid_a", ia.result_valid, m_rv);
    chk("result_valid_b", ib.result_valid, m_rv);
    if (ia.result_valid === 1'b1) begin
      if (qa_res.size() == 0) begin
        n_total++;
        $error("FAIL sb_a observed=unexpected_result expected=no_result");
      end else begin
        chk("sb_result_a", ia.result, qa_res.pop_front());
        chk("sb_sat_a", ia.result_sat, qa_sat.pop_front());
        $display("window a: result=%0d sat=%0d", ia.result, ia.result_sat);
      end
    end
    if (ib.result_valid === 1'b1) begin
      if (qb_res.size() == 0) begin
        n_total++;
        $error("FAIL sb_b observed=unexpected_result expected=no_result");
      end else begin
        chk("sb_result_b", ib.result, qb_res.pop_front());
        chk("sb_sat_b", ib.result_sat, qb_sat.pop_front());
        $display("window b: result=%0d sat=%0d", ib.result, ib.result_sat);
      end
    end
  endtask

  initial begin
    logic [7:0] s1010;
    s1010 = 8'b1010_1010;

    // Reset state
    drv_pat = 4'b1010;
    drv_ovl = 1'b1;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_result", ia.result, 0);
    chk("rst_sat", ia.result_sat, 0);
    chk("rst_count", ia.count, 0);

    // 1: overlapping 1010 over 10101010
    for (int i = 0; i < 8; i++) begin
      step(0, 1, s1010[7-i], 0);
      if (i == 3) chk("t1_cnt_bit4", ia.count, 1);
      if (i == 5) chk("t1_cnt_bit6", ia.count, 2);
      if (i == 7) chk("t1_cnt_bit8", ia.count, 3);
    end
    step(0, 0, 0, 1);
    chk("t1_result", ia.result, 3);
    chk("t1_valid", ia.result_valid, 1);
    step(0, 0, 0, 0);
    chk("t1_valid_drop", ia.result_valid, 0);

    // 2: non-overlapping, loaded at reset
    drv_ovl = 1'b0;
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, s1010[7-i], 0);
    step(0, 0, 0, 1);
    chk("t2_result", ia.result, 2);
    chk("t2_sat", ia.result_sat, 0);

    // 3: twelve ones, saturation in the 3-bit instance
    drv_pat = 4'b1111;
    drv_ovl = 1'b1;
    step(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 1, 0);
      if (i == 9) chk("t3_b_sat_at10", ib.count, 7);
    end
    step(0, 0, 0, 1);
    chk("t3_result_a", ia.result, 9);
    chk("t3_result_b", ib.result, 7);
    chk("t3_sat_b", ib.result_sat, 1);

    // 4: match on the closing cycle, none across the boundary
    drv_pat = 4'b0110;
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 1);
    chk("t4_result", ia.result, 1);
    chk("t4_count_cleared", ia.count, 0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    chk("t4_result_empty", ia.result, 0);

    // 5: qualified bits separated by idle cycles; pattern loaded via max_tick
    drv_pat = 4'b1011;
    step(0, 0, 0, 1);
    begin
      logic [3:0] s1011;
      s1011 = 4'b1011;
      for (int i = 0; i < 4; i++) begin
        step(0, 1, s1011[3-i], 0);
        if (i == 3) chk("t5_count", ia.count, 1);
        for (int j = 0; j < 3; j++) step(0, 0, ~s1011[3-i], 0);
      end
    end
    step(0, 0, 0, 1);
    chk("t5_result", ia.result, 1);
    step(0, 0, 0, 1);
    chk("t5_back_to_back", ia.result_valid, 1);

    // 6: reset mid-window, pattern from reset, mid-window pattern change ignored
    drv_pat = 4'b1111;
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0);
    chk("t6_count5", ia.count, 5);
    drv_pat = 4'b0000;
    step(0, 1, 1, 0);
    chk("t6_mid_change", ia.count, 6);
    step(1, 0, 0, 0);
    chk("t6_reset_count", ia.count, 0);
    chk("t6_reset_valid", ia.result_valid, 0);
    drv_pat = 4'b1111;
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0);
    chk("t6_ignore_new_pat", ia.count, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    chk("t6_reset_pat", ia.count, 1);
    step(0, 0, 0, 1);
    chk("t6_result", ia.result, 1);
    step(0, 0, 0, 0);

    chk("sb_a_drained", qa_res.size(), 0);
    chk("sb_b_drained", qb_res.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
